// File: rtl/pcf8574_target.sv
// pcf8574_target: I2C target emulating a PCF8574 8-bit port expander (reads enabled by PCF8574_TARGET_READ_EN)
module pcf8574_target #(
  parameter logic [6:0] ADDR        = 7'h27,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_out,
  output logic       scl_out,
  input  logic [7:0] port_in,
  output logic [7:0] port_out,
  output logic       wr_stb,
  output logic       busy
);
`ifdef PCF8574_TARGET_READ_EN
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_ADDR_ACK, S_WRITE, S_WRITE_ACK, S_READ, S_READ_ACK, S_IGNORE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_ADDR_ACK, S_WRITE, S_WRITE_ACK, S_IGNORE} state_t;
  logic unused_port_in;
  assign unused_port_in = ^port_in;
`endif
  state_t                 state_q;
  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_prev_q, sda_prev_q;
  logic [3:0]             cnt_q;
  logic [7:0]             sr_q, port_q;
  logic                   sda_q, wr_stb_q;
  logic                   scl_s, sda_s, start_c, stop_c, rise_c, fall_c, addr_hit;
  assign scl_s    = scl_sync_q[SYNC_STAGES-1];
  assign sda_s    = sda_sync_q[SYNC_STAGES-1];
  assign start_c  = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_c   = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
  assign rise_c   = scl_s & ~scl_prev_q;
  assign fall_c   = ~scl_s & scl_prev_q;
  assign addr_hit = sr_q[7:1] == ADDR;
  assign sda_out  = sda_q;
  assign scl_out  = 1'b1;
  assign port_out = port_q;
  assign wr_stb   = wr_stb_q;
  assign busy     = state_q != S_IDLE;
  // Bus line synchronizers plus one delayed copy for edge detection; idle bus is high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end
  // Protocol FSM: START/STOP override everything; sda changes only on SCL falls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      sr_q     <= 8'h00;
      port_q   <= 8'hFF;
      sda_q    <= 1'b1;
      wr_stb_q <= 1'b0;
    end else begin
      wr_stb_q <= 1'b0;
      if (stop_c) begin
        state_q <= S_IDLE;
        sda_q   <= 1'b1;
      end else if (start_c) begin
        state_q <= S_ADDR;
        sda_q   <= 1'b1;
        cnt_q   <= 4'd0;
        sr_q    <= 8'h00;
      end else begin
        case (state_q)
          S_ADDR:
            if (rise_c) begin
              sr_q  <= {sr_q[6:0], sda_s};
              cnt_q <= cnt_q + 4'd1;
            end else if (fall_c && cnt_q == 4'd8) begin
`ifdef PCF8574_TARGET_READ_EN
              if (addr_hit) begin
`else
              if (addr_hit && !sr_q[0]) begin
`endif
                state_q <= S_ADDR_ACK;
                sda_q   <= 1'b0;
              end else
                state_q <= S_IGNORE;
            end
          S_ADDR_ACK:
            if (fall_c) begin
`ifdef PCF8574_TARGET_READ_EN
              if (sr_q[0]) begin
                state_q <= S_READ;
                sr_q    <= port_in;
                sda_q   <= port_in[7];
                cnt_q   <= 4'd1;
              end else begin
                state_q <= S_WRITE;
                sda_q   <= 1'b1;
                cnt_q   <= 4'd0;
              end
`else
              state_q <= S_WRITE;
              sda_q   <= 1'b1;
              cnt_q   <= 4'd0;
`endif
            end
          S_WRITE:
            if (rise_c) begin
              sr_q  <= {sr_q[6:0], sda_s};
              cnt_q <= cnt_q + 4'd1;
            end else if (fall_c && cnt_q == 4'd8) begin
              port_q   <= sr_q;
              wr_stb_q <= 1'b1;
              sda_q    <= 1'b0;
              state_q  <= S_WRITE_ACK;
            end
          S_WRITE_ACK:
            if (fall_c) begin
              sda_q   <= 1'b1;
              cnt_q   <= 4'd0;
              state_q <= S_WRITE;
            end
`ifdef PCF8574_TARGET_READ_EN
          S_READ:
            if (fall_c) begin
              if (cnt_q == 4'd8) begin
                sda_q   <= 1'b1;
                state_q <= S_READ_ACK;
              end else begin
                sda_q <= sr_q[6];
                sr_q  <= {sr_q[6:0], 1'b1};
                cnt_q <= cnt_q + 4'd1;
              end
            end
          S_READ_ACK:
            if (rise_c && sda_s)
              state_q <= S_IGNORE;
            else if (fall_c) begin
              state_q <= S_READ;
              sr_q    <= port_in;
              sda_q   <= port_in[7];
              cnt_q   <= 4'd1;
            end
`endif
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_pcf8574_target.sv
// tb_pcf8574_target: directed I2C master bench for pcf8574_target
module tb_pcf8574_target;
  logic       clk = 1'b0, rst_n = 1'b0, scl = 1'b1, sda_m = 1'b1;
  logic [7:0] port_in = 8'hA5;
  logic       sda_in, sda_out, scl_out, wr_stb, busy;
  logic [7:0] port_out;
  int         n_cmp = 0, n_bad = 0, stb_cnt = 0, low_cnt = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
    logic       aack;
    logic       dack;
    logic [7:0] port;
    int         stb;
  } vec_t;

  assign sda_in = sda_m & sda_out;

  pcf8574_target dut (
    .clk(clk), .rst_n(rst_n), .scl_in(scl), .sda_in(sda_in), .sda_out(sda_out),
    .scl_out(scl_out), .port_in(port_in), .port_out(port_out), .wr_stb(wr_stb), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wr_stb) stb_cnt++;
    if (!sda_out) low_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic w(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_x(input logic b, output logic r);
    logic s0;
    w(2); sda_m = b; w(6); scl = 1'b1; w(1); s0 = sda_out; w(3); r = sda_in; w(3);
    chk("sda_stable_scl_high", sda_out, s0);
    w(1); scl = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_x(d[i], r);
    bit_x(1'b1, r);
    ack = ~r;
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_x(1'b1, r);
      d[i] = r;
    end
    bit_x(~mack, r);
  endtask

  task automatic i2c_start;
    w(2); sda_m = 1'b1; w(6); scl = 1'b1; w(8); sda_m = 1'b0; w(8); scl = 1'b0;
  endtask

  task automatic i2c_stop;
    w(2); sda_m = 1'b0; w(6); scl = 1'b1; w(8); sda_m = 1'b1; w(8);
  endtask

  initial begin
    vec_t       v[6];
    logic       a1, a2, r;
    logic [7:0] d;
    int         sb, lb;
    logic [7:0] kb;
    v[0] = '{8'h40, 8'h55, 1'b0, 1'b0, 8'hFF, 0};
    v[1] = '{8'h4E, 8'h3C, 1'b1, 1'b1, 8'h3C, 1};
    v[2] = '{8'h4C, 8'h00, 1'b0, 1'b0, 8'h3C, 0};
    v[3] = '{8'h4E, 8'h00, 1'b1, 1'b1, 8'h00, 1};
    v[4] = '{8'h4E, 8'hA5, 1'b1, 1'b1, 8'hA5, 1};
    v[5] = '{8'hCE, 8'h11, 1'b0, 1'b0, 8'hA5, 0};

    w(3);
    chk("rst_sda_out", sda_out, 1'b1);
    chk("rst_scl_out", scl_out, 1'b1);
    chk("rst_port_out", port_out, 8'hFF);
    chk("rst_wr_stb", wr_stb, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    w(3);
    chk("post_rst_busy", busy, 1'b0);
    chk("post_rst_port", port_out, 8'hFF);

    foreach (v[k]) begin
      sb = stb_cnt; lb = low_cnt;
      i2c_start;
      send_byte(v[k].a, a1);
      send_byte(v[k].d, a2);
      i2c_stop;
      w(4);
      chk($sformatf("vec%0d_addr_ack", k), a1, v[k].aack);
      chk($sformatf("vec%0d_data_ack", k), a2, v[k].dack);
      chk($sformatf("vec%0d_port_out", k), port_out, v[k].port);
      chk($sformatf("vec%0d_wr_stb_count", k), stb_cnt - sb, v[k].stb);
      chk($sformatf("vec%0d_sda_pulled", k), low_cnt != lb, v[k].aack);
      chk($sformatf("vec%0d_busy_after_stop", k), busy, 1'b0);
    end

    sb = stb_cnt; lb = low_cnt; kb = port_out;
    i2c_start;
    send_byte(8'h4F, a1);
`ifdef PCF8574_TARGET_READ_EN
    chk("read_addr_ack", a1, 1'b1);
    recv_byte(1'b1, d);
    chk("read_byte0", d, 8'hA5);
    recv_byte(1'b0, d);
    chk("read_byte1", d, 8'hA5);
`else
    chk("read_addr_nack", a1, 1'b0);
    chk("read_no_pull", low_cnt - lb, 0);
`endif
    i2c_stop;
    w(4);
    chk("read_busy_after_stop", busy, 1'b0);
    chk("read_port_unchanged", port_out, kb);
    chk("read_no_wr_stb", stb_cnt - sb, 0);

    sb = stb_cnt;
    i2c_start;
    send_byte(8'h4E, a1);
    send_byte(8'h12, a2);
    chk("rs_first_data_ack", a2, 1'b1);
    i2c_start;
    send_byte(8'h4E, a1);
    chk("rs_second_addr_ack", a1, 1'b1);
    send_byte(8'h34, a2);
    i2c_stop;
    w(4);
    chk("rs_wr_stb_count", stb_cnt - sb, 2);
    chk("rs_port_out", port_out, 8'h34);

    sb = stb_cnt;
    i2c_start;
    send_byte(8'h4E, a1);
    for (int i = 0; i < 4; i++) bit_x(1'b1, r);
    chk("partial_busy", busy, 1'b1);
    i2c_stop;
    w(4);
    chk("partial_stop_port", port_out, 8'h34);
    chk("partial_stop_stb", stb_cnt - sb, 0);
    chk("partial_stop_idle", busy, 1'b0);

    sb = stb_cnt;
    i2c_start;
    send_byte(8'h4E, a1);
    for (int i = 0; i < 4; i++) bit_x(1'b0, r);
    i2c_start;
    send_byte(8'h4E, a1);
    send_byte(8'h77, a2);
    i2c_stop;
    w(4);
    chk("partial_start_port", port_out, 8'h77);
    chk("partial_start_stb", stb_cnt - sb, 1);

    kb = 8'h4E;
    i2c_start;
    for (int i = 7; i >= 0; i--) bit_x(kb[i], r);
    w(2); sda_m = 1'b1; w(3);
    chk("ack_before_reset", sda_out, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("reset_sda_release", sda_out, 1'b1);
    chk("reset_port_out", port_out, 8'hFF);
    chk("reset_busy", busy, 1'b0);
    w(2); rst_n = 1'b1; w(4);
    scl = 1'b1; w(8); scl = 1'b0;
    sb = stb_cnt; lb = low_cnt;
    send_byte(8'h3C, a1);
    i2c_stop;
    w(4);
    chk("after_reset_ignored_ack", a1, 1'b0);
    chk("after_reset_no_pull", low_cnt - lb, 0);
    chk("after_reset_port", port_out, 8'hFF);
    chk("after_reset_no_stb", stb_cnt - sb, 0);
    i2c_start;
    send_byte(8'h4E, a1);
    send_byte(8'h3C, a2);
    i2c_stop;
    w(4);
    chk("recover_addr_ack", a1, 1'b1);
    chk("recover_port", port_out, 8'h3C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
